// File: rtl/ahbvga_timing_gen.sv
// ahbvga_timing_gen: AHB-Lite VGA timing and pixel generator.
// Produces HSYNC/VSYNC/DE and registered RGB for any resolution
// and porch set fixed at elaboration, with a small register file
// for enable, sync polarity, fill mode, frame count and vblank IRQ.
//
// Ports:
//   i_hclk       clock
//   i_hreset     synchronous active-high reset
//   i_hsel       AHB-Lite slave select
//   i_hready     AHB-Lite bus ready
//   i_haddr      address, bits [4:2] select the register
//   i_htrans     transfer type, bit 1 qualifies a transfer
//   i_hwrite     write strobe (address phase)
//   i_hwdata     write data (data phase)
//   o_hreadyout  always 1, zero wait state
//   o_hrdata     read data (data phase)
//   o_hsync      horizontal sync, polarity from CTRL.HPOL
//   o_vsync      vertical sync, polarity from CTRL.VPOL
//   o_de         active-video flag
//   o_rgb        pixel colour
//   o_irq        vblank interrupt, level
//
// Registers (word offsets):
//   0x00 CTRL      [0] EN [1] HPOL [2] VPOL [3] IRQ_EN [4] MODE
//   0x04 STATUS    [0] VBLANK ro, [1] IRQ_PEND write-1-to-clear
//   0x08 FRAME_CNT ro
//   0x0C BG_COLOR  [RGB_W-1:0]
//   0x10 FG_COLOR  [RGB_W-1:0]

module ahbvga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int PIX_DIV   = 1,
    parameter int RGB_W     = 8,
    parameter int CHK_SHIFT = 4
) (
    input  logic             i_hclk,
    input  logic             i_hreset,
    input  logic             i_hsel,
    input  logic             i_hready,
    input  logic [31:0]      i_haddr,
    input  logic [1:0]       i_htrans,
    input  logic             i_hwrite,
    input  logic [31:0]      i_hwdata,
    output logic             o_hreadyout,
    output logic [31:0]      o_hrdata,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic [RGB_W-1:0] o_rgb,
    output logic             o_irq
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_FRAME  = 3'd2;
    localparam logic [2:0] A_BG     = 3'd3;
    localparam logic [2:0] A_FG     = 3'd4;

    // Bus data-phase state
    logic             r_dp_wr;
    logic             r_dp_rd;
    logic [2:0]       r_dp_idx;

    // Register file
    logic [4:0]       r_ctrl;
    logic [RGB_W-1:0] r_bg;
    logic [RGB_W-1:0] r_fg;
    logic [31:0]      r_frame;
    logic             r_pend;

    // Timing counters
    logic [DW-1:0]    r_div;
    logic [HW-1:0]    r_hcnt;
    logic [VW-1:0]    r_vcnt;

    // Registered video outputs
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic [RGB_W-1:0] r_rgb;

    logic             w_sel;
    logic             w_en;
    logic             w_tick;
    logic             w_hwrap;
    logic             w_vwrap;
    logic             w_active;
    logic             w_hs;
    logic             w_vs;
    logic             w_vblank;
    logic             w_hchk;
    logic             w_vchk;
    logic             w_fg_sel;
    logic             w_irq_set;
    logic             w_irq_clr;
    logic             w_wr_ctrl;
    logic             w_wr_stat;
    logic             w_wr_bg;
    logic             w_wr_fg;
    logic [RGB_W-1:0] w_pix;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_unused = ^{i_haddr[31:5], i_haddr[1:0],
                        i_htrans[0], i_hwdata};

    // ---------------- AHB-Lite slave ----------------

    assign w_sel = i_hsel & i_hready & i_htrans[1];

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_dp_wr  <= 1'b0;
            r_dp_rd  <= 1'b0;
            r_dp_idx <= 3'd0;
        end else begin
            r_dp_wr  <= w_sel & i_hwrite;
            r_dp_rd  <= w_sel & ~i_hwrite;
            r_dp_idx <= i_haddr[4:2];
        end
    end

    assign w_wr_ctrl = r_dp_wr && (r_dp_idx == A_CTRL);
    assign w_wr_stat = r_dp_wr && (r_dp_idx == A_STATUS);
    assign w_wr_bg   = r_dp_wr && (r_dp_idx == A_BG);
    assign w_wr_fg   = r_dp_wr && (r_dp_idx == A_FG);

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_ctrl <= '0;
            r_bg   <= '0;
            r_fg   <= '0;
        end else begin
            if (w_wr_ctrl) r_ctrl <= i_hwdata[4:0];
            if (w_wr_bg)   r_bg   <= i_hwdata[RGB_W-1:0];
            if (w_wr_fg)   r_fg   <= i_hwdata[RGB_W-1:0];
        end
    end

    // Read mux works from live register values, so a read in the
    // cycle after a write already sees the written data.
    always_comb begin
        w_rdata = '0;
        if (r_dp_rd) begin
            case (r_dp_idx)
                A_CTRL:   w_rdata = 32'(r_ctrl);
                A_STATUS: w_rdata = {30'd0, r_pend, w_vblank};
                A_FRAME:  w_rdata = r_frame;
                A_BG:     w_rdata = 32'(r_bg);
                A_FG:     w_rdata = 32'(r_fg);
                default:  w_rdata = '0;
            endcase
        end
    end

    assign o_hrdata    = w_rdata;
    assign o_hreadyout = 1'b1;

    // ---------------- Timing counters ----------------

    assign w_en    = r_ctrl[0];
    assign w_tick  = w_en && (r_div == DW'(PIX_DIV - 1));
    assign w_hwrap = (r_hcnt == HW'(H_TOTAL - 1));
    assign w_vwrap = (r_vcnt == VW'(V_TOTAL - 1));

    always_ff @(posedge i_hclk) begin
        if (i_hreset || !w_en) begin
            r_div  <= '0;
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            if (w_tick) r_div <= '0;
            else        r_div <= r_div + 1'b1;
            if (w_tick) begin
                if (w_hwrap) begin
                    r_hcnt <= '0;
                    if (w_vwrap) r_vcnt <= '0;
                    else         r_vcnt <= r_vcnt + 1'b1;
                end else begin
                    r_hcnt <= r_hcnt + 1'b1;
                end
            end
        end
    end

    // ---------------- Frame counter / IRQ ----------------

    assign w_irq_set = w_tick && w_hwrap && r_ctrl[3]
                    && (r_vcnt == VW'(V_ACTIVE - 1));
    assign w_irq_clr = w_wr_stat && i_hwdata[1];

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_frame <= '0;
            r_pend  <= 1'b0;
        end else begin
            if (w_tick && w_hwrap && w_vwrap)
                r_frame <= r_frame + 32'd1;
            // set beats a coincident clear so no vblank is lost
            if (w_irq_set)      r_pend <= 1'b1;
            else if (w_irq_clr) r_pend <= 1'b0;
        end
    end

    assign o_irq = r_pend & r_ctrl[3];

    // ---------------- Video decode ----------------

    assign w_vblank = (r_vcnt >= VW'(V_ACTIVE));

    assign w_active = w_en
                   && (r_hcnt < HW'(H_ACTIVE))
                   && (r_vcnt < VW'(V_ACTIVE));

    assign w_hs = w_en
               && (r_hcnt >= HW'(HS_BEG))
               && (r_hcnt <  HW'(HS_END));

    assign w_vs = w_en
               && (r_vcnt >= VW'(VS_BEG))
               && (r_vcnt <  VW'(VS_END));

    // Checker squares larger than the counter range never toggle.
    if (CHK_SHIFT < HW) begin : g_hchk
        assign w_hchk = r_hcnt[CHK_SHIFT];
    end else begin : g_hnochk
        assign w_hchk = 1'b0;
    end

    if (CHK_SHIFT < VW) begin : g_vchk
        assign w_vchk = r_vcnt[CHK_SHIFT];
    end else begin : g_vnochk
        assign w_vchk = 1'b0;
    end

    assign w_fg_sel = r_ctrl[4] && (w_hchk ^ w_vchk);

    always_comb begin
        w_pix = '0;
        if (w_active) begin
            if (w_fg_sel) w_pix = r_fg;
            else          w_pix = r_bg;
        end
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_de    <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_hsync <= r_ctrl[1] ? w_hs : ~w_hs;
            r_vsync <= r_ctrl[2] ? w_vs : ~w_vs;
            r_de    <= w_active;
            r_rgb   <= w_pix;
        end
    end

    assign o_hsync = r_hsync;
    assign o_vsync = r_vsync;
    assign o_de    = r_de;
    assign o_rgb   = r_rgb;

endmodule

// File: tb/tb_ahbvga_timing_gen.sv
// tb_ahbvga_timing_gen: self-checking bench for ahbvga_timing_gen.
// Two small instances (PIX_DIV 1 and 3) share one AHB bus.

module tb_ahbvga_timing_gen;

    localparam logic [31:0] R_CTRL  = 32'h00;
    localparam logic [31:0] R_STAT  = 32'h04;
    localparam logic [31:0] R_FRAME = 32'h08;
    localparam logic [31:0] R_BG    = 32'h0C;
    localparam logic [31:0] R_FG    = 32'h10;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] rgb;
    } vid_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [31:0] exp;
    } reg_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic        hready;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;

    logic        rdy_a, hs_a, vs_a, de_a, irq_a;
    logic [31:0] rd_a;
    logic [7:0]  rgb_a;
    logic        rdy_b, hs_b, vs_b, de_b, irq_b;
    logic [31:0] rd_b;
    logic [7:0]  rgb_b;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] rq_a[$];
    logic [31:0] rq_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ahbvga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_DIV(1), .RGB_W(8), .CHK_SHIFT(1)
    ) u_dut_a (
        .i_hclk(clk), .i_hreset(rst),
        .i_hsel(hsel), .i_hready(hready),
        .i_haddr(haddr), .i_htrans(htrans),
        .i_hwrite(hwrite), .i_hwdata(hwdata),
        .o_hreadyout(rdy_a), .o_hrdata(rd_a),
        .o_hsync(hs_a), .o_vsync(vs_a),
        .o_de(de_a), .o_rgb(rgb_a), .o_irq(irq_a)
    );

    ahbvga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_DIV(3), .RGB_W(8), .CHK_SHIFT(1)
    ) u_dut_b (
        .i_hclk(clk), .i_hreset(rst),
        .i_hsel(hsel), .i_hready(hready),
        .i_haddr(haddr), .i_htrans(htrans),
        .i_hwrite(hwrite), .i_hwdata(hwdata),
        .o_hreadyout(rdy_b), .o_hrdata(rd_b),
        .o_hsync(hs_b), .o_vsync(vs_b),
        .o_de(de_b), .o_rgb(rgb_b), .o_irq(irq_b)
    );

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Expected output for counter state k (cycles since EN seen):
    // 16-pixel lines, 8-line frames, each pixel held div cycles.
    function automatic vid_t vexp(input int k, input int div,
                                  input logic [7:0] ctrl,
                                  input logic [7:0] bg,
                                  input logic [7:0] fg);
        vid_t r;
        logic [31:0] p, h, v;
        logic hr, vr;
        p = k / div;
        h = p % 16;
        v = (p / 16) % 8;
        r.de = ctrl[0] && h < 8 && v < 4;
        hr = ctrl[0] && h >= 10 && h < 13;
        vr = ctrl[0] && v >= 5 && v < 7;
        r.hs = ctrl[1] ? hr : !hr;
        r.vs = ctrl[2] ? vr : !vr;
        r.rgb = 8'h00;
        if (r.de)
            r.rgb = (ctrl[4] && (h[1] ^ v[1])) ? fg : bg;
        return r;
    endfunction

    task automatic bus_idle();
        hsel = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic ahb_wr(input logic [31:0] a,
                          input logic [31:0] d);
        hsel = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b1;
        haddr = a;
        @(posedge clk); #1;
        bus_idle();
        hwdata = d;
        @(posedge clk); #1;
    endtask

    task automatic ahb_rd(input logic [31:0] a,
                          input logic [31:0] ea,
                          input logic        cb,
                          input logic [31:0] eb);
        logic [31:0] e;
        hsel = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b0;
        haddr = a;
        rq_a.push_back(ea);
        rq_b.push_back(eb);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        e = rq_a.pop_front();
        chk($sformatf("rd_a %h", a), rd_a, e);
        e = rq_b.pop_front();
        if (cb) chk($sformatf("rd_b %h", a), rd_b, e);
        chk("hreadyout", 32'(rdy_a & rdy_b), 32'd1);
        @(posedge clk); #1;
    endtask

    // Call in the cycle EN becomes visible; checks kmax cycles.
    task automatic vid_run(input int kmax,
                           input logic [7:0] ctrl,
                           input logic [7:0] bg,
                           input logic [7:0] fg);
        vid_t qa[$];
        vid_t qb[$];
        vid_t e;
        for (int k = 0; k < kmax; k++) begin
            qa.push_back(vexp(k, 1, ctrl, bg, fg));
            qb.push_back(vexp(k, 3, ctrl, bg, fg));
            @(posedge clk);
            @(negedge clk);
            e = qa.pop_front();
            chk($sformatf("vid_a k=%0d", k),
                32'({de_a, hs_a, vs_a, rgb_a}), 32'(e));
            e = qb.pop_front();
            chk($sformatf("vid_b k=%0d", k),
                32'({de_b, hs_b, vs_b, rgb_b}), 32'(e));
        end
    endtask

    task automatic run_irq(input int t0, input int upto,
                           input logic e);
        while (cyc - t0 < upto) begin
            @(negedge clk);
            chk($sformatf("irq k=%0d", cyc - t0),
                32'(irq_a), 32'(e));
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_a"}, 32'({de_a, hs_a, vs_a, rgb_a, irq_a}),
            32'(12'b0_1_1_00000000_0));
        chk({nm, "_b"}, 32'({de_b, hs_b, vs_b, rgb_b, irq_b}),
            32'(12'b0_1_1_00000000_0));
    endtask

    reg_vec_t tbl[21];
    int t0;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{R_CTRL,  1'b0, 32'h0,        32'h0};
        tbl[1]  = '{R_STAT,  1'b0, 32'h0,        32'h0};
        tbl[2]  = '{R_FRAME, 1'b0, 32'h0,        32'h0};
        tbl[3]  = '{R_BG,    1'b0, 32'h0,        32'h0};
        tbl[4]  = '{R_FG,    1'b0, 32'h0,        32'h0};
        tbl[5]  = '{R_CTRL,  1'b1, 32'hFFFFFFFE, 32'h0};
        tbl[6]  = '{R_CTRL,  1'b0, 32'h0,        32'h1E};
        tbl[7]  = '{R_BG,    1'b1, 32'h12345678, 32'h0};
        tbl[8]  = '{R_BG,    1'b0, 32'h0,        32'h78};
        tbl[9]  = '{R_FG,    1'b1, 32'h0000ABCD, 32'h0};
        tbl[10] = '{R_FG,    1'b0, 32'h0,        32'hCD};
        tbl[11] = '{R_FRAME, 1'b1, 32'h5,        32'h0};
        tbl[12] = '{R_FRAME, 1'b0, 32'h0,        32'h0};
        tbl[13] = '{32'h14,  1'b1, 32'hFFFFFFFF, 32'h0};
        tbl[14] = '{32'h14,  1'b0, 32'h0,        32'h0};
        tbl[15] = '{32'h1C,  1'b0, 32'h0,        32'h0};
        tbl[16] = '{R_STAT,  1'b1, 32'h3,        32'h0};
        tbl[17] = '{R_STAT,  1'b0, 32'h0,        32'h0};
        tbl[18] = '{R_CTRL,  1'b0, 32'h0,        32'h1E};
        tbl[19] = '{R_CTRL,  1'b1, 32'h0,        32'h0};
        tbl[20] = '{R_CTRL,  1'b0, 32'h0,        32'h0};

        hready = 1'b1;
        haddr = '0;
        hwdata = '0;
        do_reset();

        @(negedge clk);
        chk_idle("reset");
        chk("reset hrdata", rd_a | rd_b, 32'h0);
        chk("reset hreadyout", 32'(rdy_a & rdy_b), 32'd1);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            if (tbl[i].wr) ahb_wr(tbl[i].addr, tbl[i].data);
            else ahb_rd(tbl[i].addr, tbl[i].exp, 1'b1, tbl[i].exp);
        end

        // back-to-back write then read of BG
        hsel = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b1;
        haddr = R_BG;
        @(posedge clk); #1;
        hwdata = 32'h55;
        hwrite = 1'b0;
        rq_a.push_back(32'h55);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        chk("raw bg", rd_a, rq_a.pop_front());
        @(posedge clk); #1;

        // solid fill, then disable mid-line, then reset mid-frame
        do_reset();
        ahb_wr(R_BG, 32'hE0);
        ahb_wr(R_CTRL, 32'h01);
        vid_run(405, 8'h01, 8'hE0, 8'h00);
        ahb_wr(R_CTRL, 32'h00);
        @(posedge clk); #1;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            chk_idle("disable");
        end
        @(posedge clk); #1;
        ahb_rd(R_FRAME, 32'd3, 1'b1, 32'd1);
        ahb_rd(R_STAT, 32'd0, 1'b1, 32'd0);
        ahb_wr(R_CTRL, 32'h01);
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle("midreset");
        @(posedge clk); #1;
        ahb_rd(R_FRAME, 32'd0, 1'b1, 32'd0);
        ahb_rd(R_CTRL, 32'd0, 1'b1, 32'd0);

        // vblank interrupt over three frames
        do_reset();
        ahb_wr(R_CTRL, 32'h09);
        t0 = cyc;
        run_irq(t0, 64, 1'b0);
        @(negedge clk);
        chk("irq rise f0", 32'(irq_a), 32'd1);
        @(posedge clk); #1;
        ahb_wr(R_STAT, 32'h2);
        run_irq(t0, 192, 1'b0);
        @(negedge clk);
        chk("irq rise f1", 32'(irq_a), 32'd1);
        @(posedge clk); #1;
        ahb_rd(R_STAT, 32'd3, 1'b0, 32'd0);
        ahb_wr(R_STAT, 32'h2);
        run_irq(t0, 258, 1'b0);
        ahb_rd(R_FRAME, 32'd2, 1'b0, 32'd0);
        ahb_rd(R_STAT, 32'd0, 1'b0, 32'd0);
        run_irq(t0, 318, 1'b0);
        ahb_wr(R_STAT, 32'h2);
        run_irq(t0, 324, 1'b1);
        ahb_rd(R_STAT, 32'd3, 1'b0, 32'd0);

        // checkerboard
        do_reset();
        ahb_wr(R_FG, 32'hFF);
        ahb_wr(R_BG, 32'h03);
        ahb_wr(R_CTRL, 32'h11);
        vid_run(400, 8'h11, 8'h03, 8'hFF);

        // active-high syncs, both dividers
        do_reset();
        ahb_wr(R_BG, 32'h5A);
        ahb_wr(R_CTRL, 32'h07);
        vid_run(800, 8'h07, 8'h5A, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
